// File: rtl/console_pkg.sv
// console_pkg: shared constants for the console writer slice.
// Geometry (160 columns, 14-bit linear address), terminal control codes,
// FSM state encodings and a printable-character helper.
package console_pkg;

  localparam int         COLS     = 160;
  localparam int         ADDR_W   = 14;
  localparam logic [7:0] LAST_COL = 8'd159;

  // Terminal control codes understood by the writer
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  // Writer FSM state encodings
  localparam logic [1:0] ST_CLR_SCREEN = 2'd0;
  localparam logic [1:0] ST_IDLE       = 2'd1;
  localparam logic [1:0] ST_CLR_LINE   = 2'd2;

  // True for bytes that are written to the screen as glyphs
  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= CH_PRINT_LO) && (ch <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/char_addr.sv
// char_addr: combinational row/column to linear buffer address.
// addr = row*160 + col, built as (row<<7) + (row<<5) + col so no multiplier
// is needed. The widest result (63*160+159 = 10239) fits in 14 bits.
module char_addr
  import console_pkg::*;
(
  input  logic [5:0]        row,
  input  logic [7:0]        col,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] row_x128_s;
  logic [ADDR_W-1:0] row_x32_s;
  logic [ADDR_W-1:0] col_ext_s;

  assign row_x128_s = {1'b0, row, 7'b0000000};
  assign row_x32_s  = {3'b000, row, 5'b00000};
  assign col_ext_s  = {6'b000000, col};
  assign addr       = row_x128_s + row_x32_s + col_ext_s;

endmodule

// File: rtl/console_writer.sv
// console_writer: terminal-style write front end for the 160xROWS character
// buffer. Takes bytes over valid/ready, tracks the cursor and issues one
// registered buffer write per cycle. Clears the whole screen after reset and
// on form feed.
// Optional feature: define CONSOLE_LINE_CLEAR_EN to blank the new row
// (160 fill writes) whenever the cursor advances to a new line. Without it
// a line advance only moves the cursor.
module console_writer
  import console_pkg::*;
#(
  parameter int         ROWS      = 64,
  parameter logic [7:0] FILL_CHAR = 8'h20
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              buf_w,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_data,
  output logic [5:0]        cur_row,
  output logic [7:0]        cur_col,
  output logic              busy
);

  // ROWS is a power of two, so wrapping the row is a mask
  localparam logic [5:0] ROW_MASK = 6'(ROWS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  logic [1:0]        state_r,    state_s;
  logic [5:0]        row_r,      row_s;
  logic [7:0]        col_r,      col_s;
  logic [5:0]        clr_row_r,  clr_row_s;
  logic [7:0]        clr_col_r,  clr_col_s;
  logic              buf_w_r,    buf_w_s;
  logic [ADDR_W-1:0] buf_addr_r, buf_addr_s;
  logic [7:0]        buf_data_r, buf_data_s;

  logic              accept_s;
  logic [5:0]        row_inc_s;
  logic [5:0]        clr_addr_row_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic [ADDR_W-1:0] clr_addr_s;

  // Ready only when idle and not being reset; derived from registered state
  assign in_ready  = (state_r == ST_IDLE) && !rst;
  assign busy      = (state_r != ST_IDLE);
  assign accept_s  = in_valid && in_ready;
  assign row_inc_s = (row_r + 6'd1) & ROW_MASK;

  // A line clear walks the cursor's (already advanced) row
  assign clr_addr_row_s = (state_r == ST_CLR_LINE) ? row_r : clr_row_r;

  char_addr u_cur_addr (
    .row  (row_r),
    .col  (col_r),
    .addr (cur_addr_s)
  );

  char_addr u_clr_addr (
    .row  (clr_addr_row_s),
    .col  (clr_col_r),
    .addr (clr_addr_s)
  );

  // Next-state, cursor and write-port decode for the writer FSM
  always_comb begin
    state_s    = state_r;
    row_s      = row_r;
    col_s      = col_r;
    clr_row_s  = clr_row_r;
    clr_col_s  = clr_col_r;
    buf_w_s    = 1'b0;
    buf_addr_s = buf_addr_r;
    buf_data_s = buf_data_r;

    case (state_r)
      ST_CLR_SCREEN: begin
        buf_w_s    = 1'b1;
        buf_addr_s = clr_addr_s;
        buf_data_s = FILL_CHAR;
        if (clr_col_r == LAST_COL) begin
          clr_col_s = 8'd0;
          if (clr_row_r == LAST_ROW) begin
            clr_row_s = 6'd0;
            state_s   = ST_IDLE;
          end else begin
            clr_row_s = clr_row_r + 6'd1;
          end
        end else begin
          clr_col_s = clr_col_r + 8'd1;
        end
      end

      ST_IDLE: begin
        if (accept_s) begin
          if (is_printable(in_data)) begin
            buf_w_s    = 1'b1;
            buf_addr_s = cur_addr_s;
            buf_data_s = in_data;
            if (col_r == LAST_COL) begin
              col_s = 8'd0;
              row_s = row_inc_s;
`ifdef CONSOLE_LINE_CLEAR_EN
              state_s   = ST_CLR_LINE;
              clr_col_s = 8'd0;
`else
              state_s   = ST_IDLE;
`endif
            end else begin
              col_s = col_r + 8'd1;
            end
          end else begin
            case (in_data)
              CH_LF: begin
                col_s = 8'd0;
                row_s = row_inc_s;
`ifdef CONSOLE_LINE_CLEAR_EN
                state_s   = ST_CLR_LINE;
                clr_col_s = 8'd0;
`else
                state_s   = ST_IDLE;
`endif
              end
              CH_CR: begin
                col_s = 8'd0;
              end
              CH_BS: begin
                if (col_r != 8'd0) begin
                  col_s = col_r - 8'd1;
                end else begin
                  col_s = col_r;
                end
              end
              CH_FF: begin
                row_s     = 6'd0;
                col_s     = 8'd0;
                clr_row_s = 6'd0;
                clr_col_s = 8'd0;
                state_s   = ST_CLR_SCREEN;
              end
              default: begin
                state_s = ST_IDLE;
              end
            endcase
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

`ifdef CONSOLE_LINE_CLEAR_EN
      ST_CLR_LINE: begin
        buf_w_s    = 1'b1;
        buf_addr_s = clr_addr_s;
        buf_data_s = FILL_CHAR;
        if (clr_col_r == LAST_COL) begin
          clr_col_s = 8'd0;
          state_s   = ST_IDLE;
        end else begin
          clr_col_s = clr_col_r + 8'd1;
        end
      end
`endif

      default: begin
        // Unknown encoding: recover by repainting the screen from the top
        state_s   = ST_CLR_SCREEN;
        row_s     = 6'd0;
        col_s     = 8'd0;
        clr_row_s = 6'd0;
        clr_col_s = 8'd0;
      end
    endcase
  end

  // State, cursor, clear counter and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_CLR_SCREEN;
      row_r      <= 6'd0;
      col_r      <= 8'd0;
      clr_row_r  <= 6'd0;
      clr_col_r  <= 8'd0;
      buf_w_r    <= 1'b0;
      buf_addr_r <= '0;
      buf_data_r <= 8'd0;
    end else begin
      state_r    <= state_s;
      row_r      <= row_s;
      col_r      <= col_s;
      clr_row_r  <= clr_row_s;
      clr_col_r  <= clr_col_s;
      buf_w_r    <= buf_w_s;
      buf_addr_r <= buf_addr_s;
      buf_data_r <= buf_data_s;
    end
  end

  assign buf_w    = buf_w_r;
  assign buf_addr = buf_addr_r;
  assign buf_data = buf_data_r;
  assign cur_row  = row_r;
  assign cur_col  = col_r;

endmodule

// File: tb/tb_console_writer.sv
// tb_console_writer: directed self-checking bench for console_writer.
// Expected values are hand-derived; line-clear expectations follow
// CONSOLE_LINE_CLEAR_EN when the bench is compiled with it.
module tb_console_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        buf_w;
  logic [13:0] buf_addr;
  logic [7:0]  buf_data;
  logic [5:0]  cur_row;
  logic [7:0]  cur_col;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [13:0] wa_q[$];
  logic [7:0]  wd_q[$];

  console_writer #(.ROWS(64), .FILL_CHAR(8'h20)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .buf_w    (buf_w),
    .buf_addr (buf_addr),
    .buf_data (buf_data),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Log every buffer write, sampled mid-cycle
  always @(negedge clk) begin
    if (buf_w === 1'b1) begin
      wa_q.push_back(buf_addr);
      wd_q.push_back(buf_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  // Present one byte, wait (bounded) for ready, complete the handshake
  task automatic send(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    wait_ready(20000, n);
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic test_reset();
    int n;
    int bad;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 5; i++) step();
    tests_run++; if (buf_w !== 1'b0) begin tests_failed++; $display("FAIL rst_buf_w: got %b want 0", buf_w); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_busy: got %b want 1", busy); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    tests_run++; if (cur_row !== 6'd0 || cur_col !== 8'd0) begin tests_failed++; $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col); end
    tests_run++; if (buf_addr !== 14'd0 || buf_data !== 8'd0) begin tests_failed++; $display("FAIL rst_port: got addr %0d data %h want 0/00", buf_addr, buf_data); end
    rst = 1'b0;
    clear_log();
    wait_ready(20000, n);
    tests_run++; if (n !== 10240) begin tests_failed++; $display("FAIL screen_clear_cycles: got %0d want 10240", n); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL screen_clear_busy: got %b want 0", busy); end
    step(); step();
    tests_run++; if (wa_q.size() !== 10240) begin tests_failed++; $display("FAIL screen_clear_count: got %0d want 10240", wa_q.size()); end
    bad = 0;
    for (int i = 0; i < wa_q.size() && i < 10240; i++)
      if (wa_q[i] !== 14'(i) || wd_q[i] !== 8'h20) bad++;
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL screen_clear_data: %0d bad entries want 0", bad); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    in_valid = 1'b1; in_data = 8'h41;
    step();
    tests_run++; if (buf_w !== 1'b1 || buf_addr !== 14'd0 || buf_data !== 8'h41) begin tests_failed++; $display("FAIL ab_first: got w%b addr %0d data %h want w1 0 41", buf_w, buf_addr, buf_data); end
    tests_run++; if (cur_col !== 8'd1) begin tests_failed++; $display("FAIL ab_col1: got %0d want 1", cur_col); end
    in_data = 8'h42;
    step();
    tests_run++; if (buf_w !== 1'b1 || buf_addr !== 14'd1 || buf_data !== 8'h42) begin tests_failed++; $display("FAIL ab_second: got w%b addr %0d data %h want w1 1 42", buf_w, buf_addr, buf_data); end
    in_valid = 1'b0; in_data = 8'h5A;
    step();
    tests_run++; if (buf_w !== 1'b0 || cur_col !== 8'd2 || cur_row !== 6'd0) begin tests_failed++; $display("FAIL ab_idle: got w%b cursor (%0d,%0d) want w0 (0,2)", buf_w, cur_row, cur_col); end
    tests_run++; if (wa_q.size() !== 2) begin tests_failed++; $display("FAIL ab_writes: got %0d want 2", wa_q.size()); end
    send(8'h0D);
    tests_run++; if (cur_col !== 8'd0 || buf_w !== 1'b0) begin tests_failed++; $display("FAIL ab_cr: got col %0d w%b want 0 w0", cur_col, buf_w); end
  endtask

  task automatic test_line_wrap();
    int bad;
    int n;
    int exp_sz;
    clear_log();
    bad = 0;
    in_valid = 1'b1; in_data = 8'h78;
    for (int i = 0; i < 160; i++) begin
      step();
      if (buf_w !== 1'b1 || buf_addr !== 14'(i)) bad++;
    end
    in_valid = 1'b0;
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL wrap_stream: %0d bad cycles want 0", bad); end
    tests_run++; if (buf_addr !== 14'd159) begin tests_failed++; $display("FAIL wrap_last_addr: got %0d want 159", buf_addr); end
    tests_run++; if (cur_row !== 6'd1 || cur_col !== 8'd0) begin tests_failed++; $display("FAIL wrap_cursor: got (%0d,%0d) want (1,0)", cur_row, cur_col); end
`ifdef CONSOLE_LINE_CLEAR_EN
    tests_run++; if (in_ready !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL wrap_clr_state: got ready %b busy %b want 0 1", in_ready, busy); end
    wait_ready(400, n);
    tests_run++; if (n !== 160) begin tests_failed++; $display("FAIL wrap_clr_cycles: got %0d want 160", n); end
    exp_sz = 320;
`else
    tests_run++; if (in_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL wrap_no_clr_state: got ready %b busy %b want 1 0", in_ready, busy); end
    for (int i = 0; i < 4; i++) step();
    n = 0;
    exp_sz = 160;
`endif
    step(); step();
    tests_run++; if (wa_q.size() !== exp_sz) begin tests_failed++; $display("FAIL wrap_writes: got %0d want %0d", wa_q.size(), exp_sz); end
    bad = 0;
    for (int i = 0; i < wa_q.size() && i < exp_sz; i++)
      if (wa_q[i] !== 14'(i) || wd_q[i] !== ((i < 160) ? 8'h78 : 8'h20)) bad++;
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL wrap_contents: %0d bad entries want 0", bad); end
  endtask

  task automatic test_lf_wrap();
    int n;
    int bad;
    logic [13:0] last_a;
    logic [7:0]  last_d;
    for (int i = 0; i < 62; i++) send(8'h0A);
    wait_ready(400, n);
    tests_run++; if (cur_row !== 6'd63 || cur_col !== 8'd0) begin tests_failed++; $display("FAIL lf_row63: got (%0d,%0d) want (63,0)", cur_row, cur_col); end
    clear_log();
    for (int i = 0; i < 5; i++) send(8'h61);
    step();
    last_a = '1; last_d = 8'h00;
    if (wa_q.size() > 0) begin last_a = wa_q[$]; last_d = wd_q[$]; end
    tests_run++; if (wa_q.size() !== 5 || last_a !== 14'd10084 || last_d !== 8'h61) begin tests_failed++; $display("FAIL lf_row63_writes: got n %0d last %0d/%h want 5 10084/61", wa_q.size(), last_a, last_d); end
    tests_run++; if (cur_row !== 6'd63 || cur_col !== 8'd5) begin tests_failed++; $display("FAIL lf_pre_cursor: got (%0d,%0d) want (63,5)", cur_row, cur_col); end
    clear_log();
    send(8'h0A);
    tests_run++; if (cur_row !== 6'd0 || cur_col !== 8'd0 || buf_w !== 1'b0) begin tests_failed++; $display("FAIL lf_wrap_cursor: got (%0d,%0d) w%b want (0,0) w0", cur_row, cur_col, buf_w); end
`ifdef CONSOLE_LINE_CLEAR_EN
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL lf_clr_busy: got %b want 1", busy); end
    wait_ready(400, n);
    tests_run++; if (n !== 160) begin tests_failed++; $display("FAIL lf_clr_cycles: got %0d want 160", n); end
    step();
    bad = 0;
    for (int i = 0; i < wa_q.size() && i < 160; i++)
      if (wa_q[i] !== 14'(i) || wd_q[i] !== 8'h20) bad++;
    tests_run++; if (wa_q.size() !== 160 || bad !== 0) begin tests_failed++; $display("FAIL lf_clr_writes: got n %0d bad %0d want 160 0", wa_q.size(), bad); end
`else
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL lf_no_clr_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 3; i++) step();
    n = 0; bad = 0;
    tests_run++; if (wa_q.size() !== 0) begin tests_failed++; $display("FAIL lf_no_clr_writes: got %0d want 0", wa_q.size()); end
`endif
  endtask

  task automatic test_bs_cr();
    int n;
    send(8'h0A); wait_ready(400, n);
    send(8'h0A); wait_ready(400, n);
    tests_run++; if (cur_row !== 6'd2 || cur_col !== 8'd0) begin tests_failed++; $display("FAIL bs_start: got (%0d,%0d) want (2,0)", cur_row, cur_col); end
    clear_log();
    send(8'h08);
    tests_run++; if (cur_row !== 6'd2 || cur_col !== 8'd0 || buf_w !== 1'b0) begin tests_failed++; $display("FAIL bs_col0: got (%0d,%0d) w%b want (2,0) w0", cur_row, cur_col, buf_w); end
    send(8'h51);
    tests_run++; if (buf_w !== 1'b1 || buf_addr !== 14'd320 || buf_data !== 8'h51 || cur_col !== 8'd1) begin tests_failed++; $display("FAIL q_write: got w%b addr %0d data %h col %0d want w1 320 51 1", buf_w, buf_addr, buf_data, cur_col); end
    send(8'h0D);
    tests_run++; if (cur_col !== 8'd0 || buf_w !== 1'b0) begin tests_failed++; $display("FAIL cr_col: got col %0d w%b want 0 w0", cur_col, buf_w); end
    send(8'h52);
    send(8'h08);
    tests_run++; if (cur_col !== 8'd0 || buf_w !== 1'b0) begin tests_failed++; $display("FAIL bs_dec: got col %0d w%b want 0 w0", cur_col, buf_w); end
    send(8'h7E);
    tests_run++; if (buf_w !== 1'b1 || buf_addr !== 14'd320 || buf_data !== 8'h7E) begin tests_failed++; $display("FAIL tilde_write: got w%b addr %0d data %h want w1 320 7e", buf_w, buf_addr, buf_data); end
    send(8'h7F);
    send(8'h1F);
    tests_run++; if (cur_row !== 6'd2 || cur_col !== 8'd1 || buf_w !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL ignored_codes: got (%0d,%0d) w%b rdy %b want (2,1) w0 rdy1", cur_row, cur_col, buf_w, in_ready); end
    step();
    tests_run++; if (wa_q.size() !== 3) begin tests_failed++; $display("FAIL bs_cr_writes: got %0d want 3", wa_q.size()); end
  endtask

  task automatic test_form_feed();
    int n;
    send(8'h0C);
    tests_run++; if (busy !== 1'b1 || in_ready !== 1'b0 || buf_w !== 1'b0) begin tests_failed++; $display("FAIL ff_state: got busy %b rdy %b w%b want 1 0 0", busy, in_ready, buf_w); end
    tests_run++; if (cur_row !== 6'd0 || cur_col !== 8'd0) begin tests_failed++; $display("FAIL ff_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col); end
    clear_log();
    wait_ready(20000, n);
    tests_run++; if (n !== 10240) begin tests_failed++; $display("FAIL ff_clear_cycles: got %0d want 10240", n); end
    step();
    tests_run++; if (wa_q.size() !== 10240) begin tests_failed++; $display("FAIL ff_clear_count: got %0d want 10240", wa_q.size()); end
  endtask

  task automatic test_rst_mid_clear();
    int n;
    send(8'h0C);
    for (int i = 0; i < 500; i++) step();
    tests_run++; if (buf_w !== 1'b1 || buf_addr !== 14'd499) begin tests_failed++; $display("FAIL mid_pre: got w%b addr %0d want w1 499", buf_w, buf_addr); end
    rst = 1'b1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
    step();
    tests_run++; if (buf_w !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_drop: got w%b busy %b want w0 busy1", buf_w, busy); end
    step();
    rst = 1'b0;
    clear_log();
    step();
    tests_run++; if (buf_w !== 1'b1 || buf_addr !== 14'd0) begin tests_failed++; $display("FAIL mid_restart: got w%b addr %0d want w1 0", buf_w, buf_addr); end
    wait_ready(20000, n);
    tests_run++; if (n !== 10239) begin tests_failed++; $display("FAIL mid_restart_cycles: got %0d want 10239", n); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_back_to_back();
    test_line_wrap();
    test_lf_wrap();
    test_bs_cr();
    test_form_feed();
    test_rst_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
